serial_bit_feeder: RTL and testbench

Parallel-to-serial front end for the sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `d_out`, with a qualifying `d_valid`. `d_out` connects directly to the `d_in` input of the downstream Mealy sequence detector. Back-to-back words stream with no idle bit between them, so patterns spanning a word boundary remain detectable.

---
 rtl/serial_bit_feeder.sv | 152 +++++++++++++++
 tb/tb_serial_bit_feeder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial front end for the sequence-detector path. Words arrive
// over a valid/ready handshake and leave one bit per clock on d_out, qualified
// by d_valid. A word offered while the last bit of the previous one is on
// d_out is taken on that same edge, so consecutive words stream with no idle
// bit between them.
//
// Handshake: a word moves on every rising clk edge where load_valid and
// load_ready are both 1. load_ready depends only on internal state, never on
// load_valid. The upstream holds load_valid and load_data steady until that
// edge. load_data is ignored whenever load_ready is 0.
//
// Parameters:
//   WIDTH     word width in bits, 2..32
//   IDLE_BIT  level on d_out while no word is shifting
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset; wins over a same-edge handshake
//   load_data   word to serialize, sampled at the handshake
//   load_valid  upstream offers load_data
//   load_ready  block takes a word this cycle (combinational)
//   d_out       serial bit (registered), feeds the detector's d_in
//   d_valid     d_out carries a data bit (registered)
//   busy        a word is in progress, i.e. the FSM is in SHIFT (registered);
//               this is also the observable copy of the FSM state
//
// Build option:
//   SERIAL_FEEDER_LSB_FIRST_EN  defined: bit 0 first, shift register moves
//                               right. Undefined: bit WIDTH-1 first, shift
//                               register moves left.
// ---------------------------------------------------------------------------
module serial_bit_feeder #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [CNT_W-1:0]   bitcnt_q;
  logic               d_out_q;
  logic               d_valid_q;
  logic               busy_q;

  logic               last_bit;
  logic               xfer;

  // The first bit of a word goes straight into d_out_q at the handshake edge,
  // so shreg_q only holds the bits still waiting, aligned so that the next one
  // to emit sits at the output end of the register.
  logic               load_bit_d;
  logic [WIDTH-1:0]   load_rest_d;
  logic               shift_bit_d;
  logic [WIDTH-1:0]   shift_rest_d;

  always_comb begin
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    load_bit_d   = load_data[0];
    load_rest_d  = load_data >> 1;
    shift_bit_d  = shreg_q[0];
    shift_rest_d = shreg_q >> 1;
`else
    load_bit_d   = load_data[WIDTH-1];
    load_rest_d  = load_data << 1;
    shift_bit_d  = shreg_q[WIDTH-1];
    shift_rest_d = shreg_q << 1;
`endif
  end

  assign last_bit   = (state_q == SHIFT) && (bitcnt_q == LAST_CNT);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign xfer       = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      d_out_q   <= IDLE_BIT;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q   <= SHIFT;
            shreg_q   <= load_rest_d;
            bitcnt_q  <= '0;
            d_out_q   <= load_bit_d;
            d_valid_q <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            d_out_q   <= IDLE_BIT;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        SHIFT: begin
          if (bitcnt_q == LAST_CNT) begin
            if (xfer) begin
              // Reload on the last-bit edge: the new word's first bit follows
              // the old word's last bit with no gap.
              shreg_q   <= load_rest_d;
              bitcnt_q  <= '0;
              d_out_q   <= load_bit_d;
              d_valid_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= IDLE;
              shreg_q   <= '0;
              bitcnt_q  <= '0;
              d_out_q   <= IDLE_BIT;
              d_valid_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end else begin
            shreg_q   <= shift_rest_d;
            bitcnt_q  <= bitcnt_q + CNT_W'(1);
            d_out_q   <= shift_bit_d;
            d_valid_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Directed steps followed by a random phase, all in one initial block. The
// reference model is a queue of the serial bits still owed: the head is the
// bit that must be on d_out this cycle, an accepted word appends its WIDTH
// bits in emission order, and the block may accept a word whenever at most
// one bit is still owed.
// ---------------------------------------------------------------------------
module tb_serial_bit_feeder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         d_out;
  logic         d_valid;
  logic         busy;

  always #5 clk = ~clk;

  serial_bit_feeder #(
    .WIDTH    (W),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .busy       (busy)
  );

  // ---------------- scoreboard state ----------------
  logic        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] got;        // serial bits seen with d_valid, newest in bit 0
  logic        accepted;   // model's view: last cycle() moved a word

  // Word bits rearranged so that bit W-1 of the result is emitted first.
  function automatic logic [W-1:0] ser_order(input logic [W-1:0] w);
    logic [W-1:0] r;
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    for (int i = 0; i < W; i++) r[W-1-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: applies inputs for this cycle, checks
  // the outputs against the model, advances the model across the rising edge
  // and returns at the next falling edge.
  task automatic cycle(input logic r, input logic lv, input logic [W-1:0] ld);
    logic         rdy_exp;
    logic [W-1:0] bits;
    rst        = r;
    load_valid = lv;
    load_data  = ld;
    #1;
    rdy_exp = (exp_q.size() <= 1);
    check_bit("load_ready", load_ready, rdy_exp);
    if (exp_q.size() > 0) begin
      check_bit("d_valid", d_valid, 1'b1);
      check_bit("d_out",   d_out,   exp_q[0]);
      check_bit("busy",    busy,    1'b1);
    end else begin
      check_bit("d_valid_idle", d_valid, 1'b0);
      check_bit("d_out_idle",   d_out,   1'b0);
      check_bit("busy_idle",    busy,    1'b0);
    end
    if (d_valid === 1'b1) got = {got[30:0], d_out};
    accepted = !r && lv && rdy_exp;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (accepted) begin
        bits = ser_order(ld);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(bits[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  logic         pend;
  logic         rnd_rst;
  logic [W-1:0] pdata;

  initial begin
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = '1;
    got        = '0;
    accepted   = 1'b0;
    pend       = 1'b0;
    pdata      = '0;

    // Reset held for two edges with load_valid high: nothing may be taken.
    @(posedge clk);
    @(negedge clk);
    cycle(1'b1, 1'b1, 8'hFF);
    idle_cycles(2);

    // Single word.
    got = '0;
    cycle(1'b0, 1'b1, 8'hB0);
    idle_cycles(9);
    check_vec("single_word", {24'h0, got[7:0]}, {24'h0, ser_order(8'hB0)});

    // Back-to-back: second word held until taken on the last-bit edge.
    got = '0;
    cycle(1'b0, 1'b1, 8'h0B);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h0D);
    idle_cycles(9);
    check_vec("back_to_back", {16'h0, got[15:0]},
              {16'h0, ser_order(8'h0B), ser_order(8'h0D)});

    // Stall: 8'hFF offered from cycle N+3, only taken at N+8.
    got = '0;
    cycle(1'b0, 1'b1, 8'h55);
    idle_cycles(2);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'hFF);
    idle_cycles(10);
    check_vec("stall", {16'h0, got[15:0]},
              {16'h0, ser_order(8'h55), ser_order(8'hFF)});

    // Mid-word reset at cycle N+4: only four bits may ever appear.
    got = '0;
    cycle(1'b0, 1'b1, 8'hAA);
    idle_cycles(3);
    cycle(1'b1, 1'b0, '0);
    idle_cycles(10);
    check_vec("mid_reset_bits", {28'h0, got[3:0]},
              {28'h0, ser_order(8'hAA) >> 4});
    check_vec("mid_reset_tail", got[31:4], 28'h0);

    // Random traffic with occasional resets; offers are held until taken.
    for (int i = 0; i < 600; i++) begin
      rnd_rst = ($urandom_range(0, 49) == 0);
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend  = 1'b1;
        pdata = W'($urandom);
      end
      cycle(rnd_rst, pend, pend ? pdata : W'($urandom));
      if (accepted || rnd_rst) pend = 1'b0;
    end
    idle_cycles(10);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
